sm_accumulator: RTL and testbench
=================================

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 SHALL provide parameter WIDTH, default 21: operand/result width in sign-magnitude; bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude.
REQ-002 SHALL provide parameter GUARD, default 8: extra internal accumulator bits; internal two's-complement width AW = WIDTH+GUARD.
REQ-003 SHALL provide parameter CNT_W, default 8: width of the term counter.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  WIDTH  sign-magnitude operand.
REQ-009 in_last  input  1  accepted beat is the final term of the sum.
REQ-010 out_valid  output  1  result held for the consumer.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_data  output  WIDTH  sign-magnitude sum.
REQ-013 out_overflow  output  1  magnitude of the sum exceeded 2^(WIDTH-1)-1.
REQ-014 out_count  output  CNT_W  number of terms summed, saturating at 2^CNT_W-1.

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-016 The FSM SHALL have states IDLE, ACC and DONE; in_ready = 1 in IDLE and ACC, 0 in DONE; out_valid = 1 only in DONE.
REQ-017 The FSM SHALL make these transitions: IDLE -> ACC on accept with in_last=0; IDLE or ACC -> DONE on accept with in_last=1; ACC stays in ACC on accept with in_last=0 and on no accept; DONE -> IDLE when out_ready=1.
REQ-018 Each operand SHALL be converted to AW-bit two's complement: sign=0 gives zero-extended magnitude, sign=1 gives the negated zero-extended magnitude; negative zero (sign=1, magnitude=0) SHALL equal zero.
REQ-019 An accept in IDLE SHALL load the accumulator with the converted operand (no stale sum); an accept in ACC SHALL add the converted operand to the accumulator.
REQ-020 The term counter SHALL load 1 on an accept in IDLE and increment on an accept in ACC, holding at 2^CNT_W-1 without wrap.
REQ-021 On the final accept, out_data, out_overflow and out_count SHALL be registered and out_valid asserted in the next cycle (latency 1 cycle from the last beat).
REQ-022 Result conversion: negative accumulator gives sign=1 and magnitude=-acc; otherwise sign=0 and magnitude=acc; a zero sum SHALL always yield sign=0.
REQ-023 out_overflow SHALL be 1 when the result magnitude exceeds 2^(WIDTH-1)-1.
REQ-024 out_data, out_overflow and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A single-beat sum (in_last=1 on the first beat) SHALL produce that operand (negative zero normalised to +0) with out_count=1.
REQ-026 Accumulator overflow beyond AW bits SHALL wrap silently; GUARD is sized by the user for the maximum term count.

Reset
REQ-027 While rst=1 at a rising edge: state <= IDLE, accumulator <= 0, counter <= 0, out_valid <= 0, out_data <= 0, out_overflow <= 0, out_count <= 0; rst SHALL take priority over any handshake.
REQ-028 Reset asserted during ACC or DONE SHALL discard the partial sum or pending result; in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-029 Macro SM_ACC_SATURATE_EN defined: on overflow, out_data SHALL be sign plus an all-ones magnitude (+/-(2^(WIDTH-1)-1)).
REQ-030 SM_ACC_SATURATE_EN undefined: on overflow, out_data SHALL be sign plus the low WIDTH-1 magnitude bits (truncation); out_overflow SHALL behave identically in both builds.

Verification (WIDTH=21, GUARD=8, CNT_W=8)
REQ-031 Beats 0x000005, 0x100003 (-3), last -> out_data=0x000002, out_count=2, out_overflow=0, out_valid exactly 1 cycle after the last accept.
REQ-032 Beats 0x000003, 0x100005, last -> out_data=0x100002; single beat 0x100000 with last -> out_data=0x000000, out_count=1.
REQ-033 Two beats 0x0FFFFF, last -> out_overflow=1; out_data=0x0FFFFF with SM_ACC_SATURATE_EN, 0x0FFFFE without; repeat with 0x1FFFFF twice -> 0x1FFFFF or 0x1FFFFE.
REQ-034 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable, no beat absorbed; out_ready=1 -> IDLE, next sum starts from zero.
REQ-035 Assert rst after 3 beats in ACC -> all outputs 0, state IDLE; next single beat 0x000007 with last -> out_data=0x000007, out_count=1.
REQ-036 300 beats of 0x000001, last on beat 300 -> out_data=0x00012C, out_count=255 (saturated).

Source files
------------

// File: rtl/sm_accumulator.sv
// Sign-magnitude accumulator: sums a burst of sign-magnitude operands in a guarded
// two's-complement register. Optional build macro SM_ACC_SATURATE_EN clamps an overflowed result.
module sm_accumulator #(
    parameter int WIDTH = 21,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam int AW = WIDTH + GUARD;
    localparam int MW = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_ovf_q, res_ovf_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    logic             accept;
    logic [AW-1:0]    mag_ext;
    logic [AW-1:0]    operand;
    logic [AW-1:0]    acc_base;
    logic [AW-1:0]    sum;
    logic [CNT_W-1:0] cnt_next;
    logic             res_neg;
    logic [AW-1:0]    res_mag;
    logic             res_ovf;
    logic [MW-1:0]    res_mag_out;
    logic [WIDTH-1:0] res_data;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    assign mag_ext = {{(AW-MW){1'b0}}, in_data[MW-1:0]};
    assign operand = in_data[WIDTH-1] ? (~mag_ext + AW'(1)) : mag_ext;

    // The first beat of a sum loads rather than adds, so no stale total survives.
    assign acc_base = (state_q == IDLE) ? '0 : acc_q;
    assign sum      = acc_base + operand;

    assign cnt_next = (state_q == IDLE) ? CNT_W'(1)
                    : (cnt_q == CNT_MAX) ? cnt_q
                    : cnt_q + CNT_W'(1);

    assign res_neg = sum[AW-1];
    assign res_mag = res_neg ? (~sum + AW'(1)) : sum;
    assign res_ovf = |res_mag[AW-1:MW];

`ifdef SM_ACC_SATURATE_EN
    assign res_mag_out = res_ovf ? {MW{1'b1}} : res_mag[MW-1:0];
`else
    assign res_mag_out = res_mag[MW-1:0];
`endif

    assign res_data = {res_neg, res_mag_out};

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_ovf_d  = res_ovf_q;
        res_cnt_d  = res_cnt_q;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_next;
                    if (in_last) begin
                        state_d    = DONE;
                        res_data_d = res_data;
                        res_ovf_d  = res_ovf;
                        res_cnt_d  = cnt_next;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    assign out_data     = res_data_q;
    assign out_overflow = res_ovf_q;
    assign out_count    = res_cnt_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed self-checking bench for sm_accumulator at WIDTH=21, GUARD=8, CNT_W=8.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_sm_accumulator;

    localparam int WIDTH = 21;
    localparam int GUARD = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic [CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    sm_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [WIDTH-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL take: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; idle_in();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: out_valid=%b out_overflow=%b, required 0/0", out_valid, out_overflow);
        end
        n_checks++;
        if (out_data !== 21'h0 || out_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_data: out_data=%h out_count=%0d, required 0/0", out_data, out_count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic_sum();
        beat(21'h000005, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_acc_state: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        beat(21'h100003, 1'b1);
        idle_in();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_latency: out_valid=%b, required 1", out_valid);
        end
        n_checks++;
        if (out_data !== 21'h000002 || out_count !== 8'd2 || out_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_result: data=%h count=%0d ovf=%b, required 000002/2/0", out_data, out_count, out_overflow);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_ready: in_ready=%b, required 0", in_ready);
        end
        take();
    endtask

    task automatic test_negative();
        beat(21'h000003, 1'b0);
        beat(21'h100005, 1'b1);
        idle_in();
        n_checks++;
        if (out_data !== 21'h100002 || out_count !== 8'd2 || out_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL neg_result: data=%h count=%0d ovf=%b, required 100002/2/0", out_data, out_count, out_overflow);
        end
        take();
        beat(21'h100000, 1'b1);
        idle_in();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 21'h000000 || out_count !== 8'd1) begin
            n_errors++;
            $display("FAIL neg_zero: valid=%b data=%h count=%0d, required 1/000000/1", out_valid, out_data, out_count);
        end
        take();
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp_pos;
        logic [WIDTH-1:0] exp_neg;
`ifdef SM_ACC_SATURATE_EN
        exp_pos = 21'h0FFFFF;
        exp_neg = 21'h1FFFFF;
`else
        exp_pos = 21'h0FFFFE;
        exp_neg = 21'h1FFFFE;
`endif
        beat(21'h0FFFFF, 1'b0);
        beat(21'h0FFFFF, 1'b1);
        idle_in();
        n_checks++;
        if (out_overflow !== 1'b1 || out_data !== exp_pos || out_count !== 8'd2) begin
            n_errors++;
            $display("FAIL ovf_pos: ovf=%b data=%h count=%0d, required 1/%h/2", out_overflow, out_data, out_count, exp_pos);
        end
        take();
        beat(21'h1FFFFF, 1'b0);
        beat(21'h1FFFFF, 1'b1);
        idle_in();
        n_checks++;
        if (out_overflow !== 1'b1 || out_data !== exp_neg) begin
            n_errors++;
            $display("FAIL ovf_neg: ovf=%b data=%h, required 1/%h", out_overflow, out_data, exp_neg);
        end
        take();
        // Largest representable magnitude must not flag overflow.
        beat(21'h0FFFFE, 1'b0);
        beat(21'h000001, 1'b1);
        idle_in();
        n_checks++;
        if (out_overflow !== 1'b0 || out_data !== 21'h0FFFFF) begin
            n_errors++;
            $display("FAIL ovf_edge: ovf=%b data=%h, required 0/0fffff", out_overflow, out_data);
        end
        take();
    endtask

    task automatic test_backpressure();
        beat(21'h000004, 1'b0);
        beat(21'h000006, 1'b1);
        in_valid = 1'b1;
        in_data  = 21'h000100;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 21'h00000A ||
                out_count !== 8'd2 || out_overflow !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_%0d: valid=%b ready=%b data=%h count=%0d ovf=%b, required 1/0/00000a/2/0",
                         i, out_valid, in_ready, out_data, out_count, out_overflow);
            end
            @(negedge clk);
        end
        idle_in();
        take();
        beat(21'h000009, 1'b1);
        idle_in();
        n_checks++;
        if (out_data !== 21'h000009 || out_count !== 8'd1) begin
            n_errors++;
            $display("FAIL after_hold: data=%h count=%0d, required 000009/1", out_data, out_count);
        end
        take();
    endtask

    task automatic test_reset_mid();
        beat(21'h000005, 1'b0);
        beat(21'h000006, 1'b0);
        beat(21'h000007, 1'b0);
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 21'h0 || out_overflow !== 1'b0 ||
            out_count !== 8'd0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b data=%h ovf=%b count=%0d ready=%b, required 0/0/0/0/1",
                     out_valid, out_data, out_overflow, out_count, in_ready);
        end
        beat(21'h000007, 1'b1);
        idle_in();
        n_checks++;
        if (out_data !== 21'h000007 || out_count !== 8'd1) begin
            n_errors++;
            $display("FAIL post_reset: data=%h count=%0d, required 000007/1", out_data, out_count);
        end
        take();
    endtask

    task automatic test_saturating_count();
        for (int i = 1; i <= 300; i++) begin
            beat(21'h000001, (i == 300));
        end
        idle_in();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 21'h00012C || out_count !== 8'd255 || out_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL long_sum: valid=%b data=%h count=%0d ovf=%b, required 1/00012c/255/0",
                     out_valid, out_data, out_count, out_overflow);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_negative();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_saturating_count();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
